// File: rtl/axi_r_arbiter.sv
// ---------------------------------------------------------------------------
// axi_r_arbiter
//   Shares a single downstream AXI read master between an icache (port 0)
//   and a dcache (port 1). Only one transaction is outstanding at a time.
//   Ties are broken round-robin (RoundRobin=1) or in favour of the dcache
//   (RoundRobin=0). A burst-length mismatch between the latched arlen and
//   the observed rlast produces a one-cycle err_o pulse.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   ic_req_i   : icache AR/R master signals      ic_rsp_o : icache response
//   dc_req_i   : dcache AR/R master signals      dc_rsp_o : dcache response
//   mem_req_o  : downstream AR/R master signals  mem_rsp_i: downstream response
//   grant_o    : one-hot owner (bit0 icache, bit1 dcache), 0 when idle
//   err_o      : one-cycle pulse on burst-length mismatch
//
// States
//   IDLE | no owner; arbitrate requests, all outputs 0
//   ADDR | address phase of the granted port forwarded downstream
//   DATA | read beats of the granted port forwarded upstream
// ---------------------------------------------------------------------------
package axi_r_arbiter_pkg;
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_r_s2m_t;
endpackage

module axi_r_arbiter
    import axi_r_arbiter_pkg::*;
#(
    parameter int RoundRobin = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  axi_r_m2s_t ic_req_i,
    output axi_r_s2m_t ic_rsp_o,
    input  axi_r_m2s_t dc_req_i,
    output axi_r_s2m_t dc_rsp_o,
    output axi_r_m2s_t mem_req_o,
    input  axi_r_s2m_t mem_rsp_i,
    output logic [1:0] grant_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_grant;
    logic       r_rr_dc_last;   // 1 = dcache was served last
    logic [7:0] r_beat_lim;
    logic [7:0] r_beat_cnt;

    logic       w_any_req;
    logic       w_tie_dc;
    logic       w_win_dc;
    axi_r_m2s_t w_sel;
    logic       w_beat;

    assign w_any_req = ic_req_i.arvalid | dc_req_i.arvalid;

    always_comb begin
        if (RoundRobin != 0) begin
            w_tie_dc = ~r_rr_dc_last;
        end else begin
            w_tie_dc = 1'b1;
        end
    end

    // A lone requester wins regardless of the pointer.
    assign w_win_dc = dc_req_i.arvalid & (~ic_req_i.arvalid | w_tie_dc);
    assign w_sel    = r_grant[1] ? dc_req_i : ic_req_i;
    assign w_beat   = mem_rsp_i.rvalid & w_sel.rready;
    assign grant_o  = r_grant;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a dropped arvalid in ADDR keeps the FSM in ADDR.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_ADDR;
            ST_ADDR: if (w_sel.arvalid && mem_rsp_i.arready) w_state_nxt = ST_DATA;
            ST_DATA: if (w_beat && mem_rsp_i.rlast) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, beat limit/counter and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant      <= 2'b00;
            r_rr_dc_last <= 1'b0;
            r_beat_lim   <= 8'd0;
            r_beat_cnt   <= 8'd0;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant    <= w_win_dc ? 2'b10 : 2'b01;
                r_beat_lim <= w_win_dc ? dc_req_i.arlen : ic_req_i.arlen;
                r_beat_cnt <= 8'd0;
            end else if (r_state == ST_DATA && w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (mem_rsp_i.rlast) begin
                    r_grant      <= 2'b00;
                    r_rr_dc_last <= r_grant[1];
                end
            end
        end
    end

    // Output logic
    always_comb begin
        mem_req_o = '0;
        ic_rsp_o  = '0;
        dc_rsp_o  = '0;
        err_o     = 1'b0;
        case (r_state)
            ST_ADDR: begin
                mem_req_o        = w_sel;
                mem_req_o.rready = 1'b0;
                if (r_grant[1]) begin
                    dc_rsp_o.arready = mem_rsp_i.arready;
                end else begin
                    ic_rsp_o.arready = mem_rsp_i.arready;
                end
            end
            ST_DATA: begin
                mem_req_o.rready = w_sel.rready;
                if (r_grant[1]) begin
                    dc_rsp_o.rvalid = mem_rsp_i.rvalid;
                    dc_rsp_o.rdata  = mem_rsp_i.rdata;
                    dc_rsp_o.rlast  = mem_rsp_i.rlast;
                end else begin
                    ic_rsp_o.rvalid = mem_rsp_i.rvalid;
                    ic_rsp_o.rdata  = mem_rsp_i.rdata;
                    ic_rsp_o.rlast  = mem_rsp_i.rlast;
                end
                // Counter holds the index of the beat currently presented.
                if (w_beat) begin
                    if (mem_rsp_i.rlast) begin
                        err_o = (r_beat_cnt != r_beat_lim);
                    end else begin
                        err_o = (r_beat_cnt == r_beat_lim);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi_r_arbiter.md
AXI_R_ARBITER -- requirements
Module: axi_r_arbiter

Interface
REQ-001 SHALL have parameter RoundRobin, default 1, meaning 1 = round-robin between ports and 0 = fixed priority to port 1 (dcache).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ic_req_i  input  axi_r_m2s_t (47)  icache read request, port 0.
REQ-005 SHALL have port ic_rsp_o  output  axi_r_s2m_t (35)  icache read response.
REQ-006 SHALL have port dc_req_i  input  axi_r_m2s_t (47)  dcache read request, port 1.
REQ-007 SHALL have port dc_rsp_o  output  axi_r_s2m_t (35)  dcache read response.
REQ-008 SHALL have port mem_req_o  output  axi_r_m2s_t (47)  shared downstream AXI read master.
REQ-009 SHALL have port mem_rsp_i  input  axi_r_s2m_t (35)  downstream read response.
REQ-010 SHALL have port grant_o  output  2  one-hot owner (bit0 icache, bit1 dcache); 0 when idle.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on burst-length mismatch.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA; at most one transaction is outstanding.
REQ-013 In IDLE, a request is any port with arvalid=1; with none, the FSM SHALL stay in IDLE.
REQ-014 In IDLE with a request, the FSM SHALL register the winner into grant, latch its arlen into a beat limit, clear the beat counter, and go to ADDR next cycle.
REQ-015 Arbitration SHALL work as follows when both ports request:
- RoundRobin=1: grant the port not served last; the pointer resets to "icache served last", so dcache wins the first tie.
- RoundRobin=0: dcache always wins.
REQ-016 A single requester SHALL be granted regardless of the pointer.
REQ-017 In ADDR, mem_req_o address-channel fields SHALL be driven combinationally from the granted port. The granted port's arready = mem_rsp_i.arready.
REQ-018 In ADDR, the non-granted port's arready SHALL be 0.
REQ-019 ADDR SHALL go to DATA on mem arvalid & arready. First mem arvalid is therefore one cycle after the request arvalid.
REQ-020 In DATA, mem_req_o.arvalid SHALL be 0 and mem rready = granted port's rready.
REQ-021 In DATA, the granted port SHALL receive rvalid, rdata and rlast unchanged.
REQ-022 The non-granted port SHALL see rvalid=0, rlast=0, rdata=0 and arready=0 in every state.
REQ-023 Each rvalid & rready in DATA SHALL increment an 8-bit beat counter.
REQ-024 On rvalid & rready & rlast, the FSM SHALL return to IDLE, record the served port in the RR pointer, and clear grant.
REQ-025 err_o SHALL pulse for one cycle on the following mismatches:
- rlast arrives with the counter not equal to the latched arlen.
- A beat with counter == arlen arrives without rlast; the FSM then stays in DATA until rlast.
REQ-026 A new request arriving while the FSM is in IDLE after completion SHALL be arbitrated the same cycle. There is no dead cycle beyond the IDLE state itself.
REQ-027 Requests asserted during ADDR/DATA by the non-granted port SHALL be held off (arready=0) and arbitrated on the next IDLE; no request is dropped.
REQ-028 The granted port's deassertion of arvalid in ADDR is a protocol violation.
- The arbiter SHALL NOT leave ADDR.
- It forwards arvalid as given.
REQ-029 In IDLE, all mem_req_o fields SHALL be 0 and both response outputs SHALL be 0.

Reset
REQ-030 When rst_ni=0, asynchronously: FSM=IDLE, grant_o=0, RR pointer=icache-last, beat counter=0, err_o=0, all mem_req_o and response outputs 0.
REQ-031 Reset asserted mid-ADDR/DATA SHALL abandon the transaction; downstream beats in flight are not drained, and the system resets the memory side concurrently.

Verification
REQ-032 Single icache burst: ic arvalid, araddr=0x8000_0000, arlen=7; mem arready after 2 cycles; 8 beats with rlast on the 8th -> ic receives 8 beats, grant_o=01 throughout, IDLE after last beat, err_o never 1.
REQ-033 Simultaneous requests, RoundRobin=1, out of reset: ic arlen=7 and dc arlen=0 -> dc served first (grant_o=10), ic arready=0 until dc rlast, then ic granted; next tie goes to dc again only after ic served.
REQ-034 RoundRobin=0, dc requesting continuously, ic requesting -> ic never granted while dc arvalid is high at IDLE; ic granted the first IDLE cycle in which dc arvalid=0.
REQ-035 Length mismatch: dc arlen=3, slave asserts rlast on beat 2 -> err_o pulses exactly once in that cycle, FSM returns to IDLE.
REQ-036 Backpressure: granted rready toggling 1/0 each cycle during an 8-beat burst -> mem rready mirrors it, counter advances only on handshake cycles, completion after 8 handshakes.
REQ-037 Reset mid-DATA after beat 3: rst_ni low -> within the same cycle grant_o=0 and all outputs 0; after release, a fresh ic request is granted normally.
